inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage that replaces the bare PC/instruction-memory pairing ahead of decode.
- Owns the fetch PC and issues word requests to an instruction memory over a req/ready handshake that may insert wait states.
- Buffers returned instructions, with their PC and PC+4, in a small prefetch FIFO that the decode/control stage drains with valid/ready.
- Accepts branch/jump redirects from downstream, flushing the FIFO and restarting fetch at the target.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-low (0 = reset)
start_i  input  1  fetch enable, level-sensitive
redirect_i  input  1  branch taken / jump this cycle
redirect_pc_i  input  32  redirect target (word aligned)
imem_req_o  output  1  memory request valid
imem_addr_o  output  32  request address
imem_ready_i  input  1  memory accepts request; imem_data_i valid this cycle
imem_data_i  input  32  instruction word
inst_valid_o  output  1  FIFO head valid
inst_o  output  32  head instruction
inst_pc_o  output  32  head instruction address
inst_pc4_o  output  32  head address + 4
inst_ready_i  input  1  decode consumes head
count_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i==0 at edge):
  - fetch_pc=RESET_PC, FIFO empty, count_o=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_valid_o=0; inst_o, inst_pc_o, inst_pc4_o = 0.
  - Reset overrides every other input, including a mid-request cycle.
- Request issue:
  - imem_req_o is registered.
  - It is set next cycle when start_i==1 and count + (request in progress) < DEPTH.
  - imem_addr_o = fetch_pc, always word aligned; bits [1:0] are 0.
- Handshake:
  - Once imem_req_o==1, req and addr hold stable until imem_ready_i==1, even if start_i drops or the FIFO state changes.
  - The only exception is redirect.
  - Handshake completes in any cycle with req&ready.
  - On completion, push {fetch_pc, imem_data_i} and fetch_pc += 4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal).
  - Back-to-back: req may stay high on the following cycle if space remains, giving one word per cycle at zero wait states.
- Output:
  - inst_valid_o = FIFO non-empty. The head is registered, so there is no combinational path from imem_data_i.
  - Pop when inst_valid_o & inst_ready_i.
  - Minimum latency: ready at edge N -> inst_valid_o=1 after edge N+1.
  - inst_pc4_o = inst_pc_o + 4.
- Full/empty:
  - No push is ever attempted when full; issue logic guarantees this.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty is ignored.
- Redirect (redirect_i==1), highest priority after reset:
  - FIFO flushed, count=0; any pop that cycle is ignored.
  - fetch_pc = redirect_pc_i.
  - Any in-progress request is abandoned: imem_req_o=0 next cycle. Data returned in the redirect cycle, even with ready==1, is discarded.
  - The earliest new request, addr = target, is asserted the cycle after that.
  - The memory must tolerate req dropping without ready.
- Redirect while start_i==0: fetch_pc updated, no request issued.
- Back-to-back redirects: the last one wins.
- start_i deasserted: no new requests; buffered entries remain poppable.

Decomposition:
- Shared package holds: WORD_BYTES=4, INST_W=32, RESET_PC default, and a typedef for the fetch entry {pc[31:0], inst[31:0]}.
- One sub-module, fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush, count, and registered head.
- Issue/handshake control stays in inst_fetch_unit.

Test Plan:
- Reset then start_i=1, zero-wait memory returning addr as data, inst_ready_i=1 -> requests at 0,4,8,...; inst_valid_o from cycle 3; inst_o/inst_pc_o = 0,4,8 one per cycle; inst_pc4_o = 4,8,12.
- Memory inserts 2 wait states on addr 4 -> imem_req_o/imem_addr_o=4 held stable 3 cycles; no duplicate or lost entries.
- inst_ready_i=0, DEPTH=4 -> exactly 4 pushes, count_o=4, imem_req_o=0; raise inst_ready_i -> fetch resumes at 16 with no gap in PCs.
- FIFO holding 3 entries, redirect_i=1 with redirect_pc_i=32'h100 while a req at 12 is completed that cycle -> count_o=0 next cycle; word 12 discarded; next request addr 32'h100; first output pc 32'h100, pc4 32'h104.
- rst_i=0 asserted mid-wait-state -> next cycle imem_req_o=0, inst_valid_o=0, count_o=0; after release, fetch restarts at RESET_PC.
- fetch_pc=32'hFFFF_FFFC -> output pc FFFF_FFFC with pc4 0; next request addr 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and the fetch entry type for the instruction fetch stage.
package inst_fetch_unit_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, flush wins over push/pop, head read from the
// storage registers so nothing reaches the head combinationally from push_data.
module inst_fetch_unit_fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop on empty is dropped; push is only ever requested with space free.
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care while not covered by count.
    always_ff @(posedge clk_i) begin
        if (rst_i && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the imem req/ready handshake and feeds
// the prefetch FIFO drained by decode; redirects flush and restart fetch.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ready_i,
    input  logic [31:0]              imem_data_i,
    output logic                     inst_valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [31:0]              inst_pc_o,
    output logic [31:0]              inst_pc4_o,
    input  logic                     inst_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic             req_q;
    logic             handshake;
    logic             push;
    logic [CNT_W:0]   pending;
    logic             can_issue;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             head_valid;
    logic [CNT_W-1:0] count;

    // A new request is allowed only if the FIFO can absorb it even when the
    // request already in flight lands first; pops are ignored (conservative).
    assign handshake  = req_q && imem_ready_i;
    assign push       = handshake && !redirect_i;
    assign pending    = {1'b0, count} + (CNT_W+1)'(req_q);
    assign can_issue  = start_i && (pending < (CNT_W+1)'(DEPTH));
    assign push_entry = '{pc: fetch_pc, inst: imem_data_i};

    // Fetch PC and request register; an un-acked request holds unless redirected.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_q    <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            req_q    <= 1'b0;
        end else begin
            if (handshake) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
            if (req_q && !imem_ready_i) req_q <= 1'b1;
            else                        req_q <= can_issue;
        end
    end

    inst_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .pop        (inst_ready_i),
        .flush      (redirect_i),
        .push_data  (push_entry),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    // Head fields read as zero while the FIFO is empty.
    assign imem_req_o   = req_q;
    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head.inst : '0;
    assign inst_pc_o    = head_valid ? head.pc   : '0;
    assign inst_pc4_o   = head_valid ? head.pc + 32'(WORD_BYTES) : '0;
    assign count_o      = count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a vector table for the streaming and
// backpressure flow, hand sequences for wait states, redirect, reset and wrap.
module tb_inst_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NONE  = 32'hDEAD_0000;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_pc4_o;
    logic        inst_ready_i;
    logic [2:0]  count_o;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_data_i   (imem_data_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_pc4_o    (inst_pc4_o),
        .inst_ready_i  (inst_ready_i),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data = addr ^ KEY; slow_addr answers after 2 wait states.
    logic [31:0] slow_addr;
    logic [1:0]  wcnt;
    assign imem_ready_i = imem_req_o && ((imem_addr_o != slow_addr) || (wcnt == 2'd2));
    assign imem_data_i  = imem_addr_o ^ KEY;

    always @(posedge clk) begin
        if (!imem_req_o || imem_ready_i) wcnt <= 2'd0;
        else if (wcnt != 2'd3)           wcnt <= wcnt + 2'd1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc, input logic [2:0] e_cnt);
        chk({tag, ".req"},   32'(imem_req_o),   32'(e_req));
        chk({tag, ".addr"},  imem_addr_o,       e_addr);
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'(e_valid));
        chk({tag, ".count"}, 32'(count_o),      32'(e_cnt));
        if (e_valid) begin
            chk({tag, ".pc"},   inst_pc_o,  e_pc);
            chk({tag, ".pc4"},  inst_pc4_o, e_pc + 32'd4);
            chk({tag, ".inst"}, inst_o,     e_pc ^ KEY);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst_i         = r;
        start_i       = s;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        inst_ready_i  = rdy;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [18];

    initial begin
        rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = '0; inst_ready_i = 1'b0; slow_addr = NONE;

        //          rst st rdy  req addr  vld pc   cnt
        tbl[0]  = '{0, 0, 1,   0, 0,     0, 0,   0};
        tbl[1]  = '{0, 1, 1,   0, 0,     0, 0,   0};
        tbl[2]  = '{1, 1, 1,   1, 0,     0, 0,   0};
        tbl[3]  = '{1, 1, 1,   1, 4,     1, 0,   1};
        tbl[4]  = '{1, 1, 1,   1, 8,     1, 4,   1};
        tbl[5]  = '{1, 1, 1,   1, 12,    1, 8,   1};
        tbl[6]  = '{1, 1, 1,   1, 16,    1, 12,  1};
        tbl[7]  = '{1, 1, 0,   1, 20,    1, 12,  2};
        tbl[8]  = '{1, 1, 0,   1, 24,    1, 12,  3};
        tbl[9]  = '{1, 1, 0,   0, 28,    1, 12,  4};
        tbl[10] = '{1, 1, 0,   0, 28,    1, 12,  4};
        tbl[11] = '{1, 1, 1,   0, 28,    1, 16,  3};
        tbl[12] = '{1, 1, 1,   1, 28,    1, 20,  2};
        tbl[13] = '{1, 1, 1,   1, 32,    1, 24,  2};
        tbl[14] = '{1, 1, 1,   1, 36,    1, 28,  2};
        tbl[15] = '{1, 0, 1,   0, 40,    1, 32,  2};
        tbl[16] = '{1, 0, 1,   0, 40,    1, 36,  1};
        tbl[17] = '{1, 0, 1,   0, 40,    0, 0,   0};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst_n, tbl[i].start, 1'b0, 32'h0, tbl[i].rdy);
            check_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                      tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt);
        end

        // Two wait states on addr 4: request held for three cycles, no loss/dup.
        slow_addr = 32'h4;
        step(0, 0, 0, 0, 1); check_out("ws.rst",  0, 0,  0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("ws.c0",   1, 0,  0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("ws.c1",   1, 4,  1, 0, 1);
        step(1, 1, 0, 0, 1); check_out("ws.c2",   1, 4,  0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("ws.c3",   1, 4,  0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("ws.c4",   1, 8,  1, 4, 1);
        step(1, 1, 0, 0, 1); check_out("ws.c5",   1, 12, 1, 8, 1);

        // Reset in the middle of a wait state, then restart from RESET_PC.
        step(0, 0, 0, 0, 0); check_out("mr.rst",  0, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("mr.c0",   1, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("mr.c1",   1, 4,  1, 0, 1);
        step(0, 1, 0, 0, 0); check_out("mr.mid",  0, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("mr.c2",   1, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("mr.c3",   1, 4,  1, 0, 1);

        // Redirect with 3 buffered entries while the request at 12 completes.
        slow_addr = NONE;
        step(0, 0, 0, 0, 0); check_out("rd.rst",  0, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("rd.c0",   1, 0,  0, 0, 0);
        step(1, 1, 0, 0, 0); check_out("rd.c1",   1, 4,  1, 0, 1);
        step(1, 1, 0, 0, 0); check_out("rd.c2",   1, 8,  1, 0, 2);
        step(1, 1, 0, 0, 0); check_out("rd.c3",   1, 12, 1, 0, 3);
        step(1, 1, 1, 32'h100, 1); check_out("rd.flush", 0, 32'h100, 0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("rd.c4",   1, 32'h100, 0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("rd.c5",   1, 32'h104, 1, 32'h100, 1);
        step(1, 1, 0, 0, 1); check_out("rd.c6",   1, 32'h108, 1, 32'h104, 1);

        // Redirect with fetch disabled, then wrap from FFFF_FFFC to 0.
        step(1, 0, 1, 32'hFFFF_FFFC, 1); check_out("wr.redir", 0, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, 0, 0, 1); check_out("wr.idle", 0, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("wr.c0",   1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 1, 0, 0, 1); check_out("wr.c1",   1, 32'h0, 1, 32'hFFFF_FFFC, 1);
        chk("wr.pc4_zero", inst_pc4_o, 32'h0);
        step(1, 1, 0, 0, 1); check_out("wr.c2",   1, 32'h4, 1, 32'h0, 1);

        // Back-to-back redirects: the later target wins.
        step(1, 1, 1, 32'h200, 1); check_out("bb.r0", 0, 32'h200, 0, 0, 0);
        step(1, 1, 1, 32'h300, 1); check_out("bb.r1", 0, 32'h300, 0, 0, 0);
        step(1, 1, 0, 0, 1);       check_out("bb.c0", 1, 32'h300, 0, 0, 0);
        step(1, 1, 0, 0, 1);       check_out("bb.c1", 1, 32'h304, 1, 32'h300, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
